// File: rtl/serial_mag_comp.sv
// -----------------------------------------------------------------------------
// serial_mag_comp
//
// Bit-serial magnitude comparator. On an accepted start pulse the two WIDTH-bit
// operands and the signed/unsigned mode are latched. The operands are then
// compared MSB-first, one bit per clock. In signed mode a difference in the
// sign bit reverses the sense of the comparison. With EARLY_EXIT=1 the scan
// stops at the first differing bit; with EARLY_EXIT=0 it always runs all WIDTH
// bits and keeps the first difference it saw.
//
// Ports
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   start        request; only sampled while busy=0
//   signed_mode  1 = two's-complement compare (latched with operands)
//   a, b         operands (latched on accepted start)
//   busy         compare in progress
//   done         one-cycle pulse when gt/eq/lt/cycles update
//   gt, eq, lt   registered result flags (exactly one high after completion)
//   cycles       number of bit-compare cycles used by the last operation
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         signed_mode,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic                         busy,
    output logic                         done,
    output logic                         gt,
    output logic                         eq,
    output logic                         lt,
    output logic [$clog2(WIDTH+1)-1:0]   cycles
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // Pending result used when the scan continues past the first difference.
    logic              pend_vld_q, pend_vld_d;
    logic              pend_gt_q, pend_gt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              gt_q, gt_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic [CW-1:0]     cycles_q, cycles_d;

    // Current bit of each operand; shifting avoids an index wider than needed.
    logic [WIDTH-1:0]  a_sh, b_sh;
    logic              bit_a, bit_b, bit_diff, a_wins;
    logic              res_vld, res_gt, last_cycle;
    logic [CW-1:0]     cnt_nx;

    always_comb begin
        a_sh     = a_q >> idx_q;
        b_sh     = b_q >> idx_q;
        bit_a    = a_sh[0];
        bit_b    = b_sh[0];
        bit_diff = bit_a ^ bit_b;
        // In signed mode a 1 in the sign bit marks the smaller operand.
        a_wins   = (sgn_q && (idx_q == IDX_MSB)) ? bit_b : bit_a;
        // The first difference wins; later ones are ignored.
        res_vld  = pend_vld_q | bit_diff;
        res_gt   = pend_vld_q ? pend_gt_q : a_wins;
        last_cycle = (idx_q == '0) || ((EARLY_EXIT != 0) && bit_diff);
        cnt_nx   = cnt_q + CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sgn_d      = sgn_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_gt_d  = pend_gt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        gt_d       = gt_q;
        eq_d       = eq_q;
        lt_d       = lt_q;
        cycles_d   = cycles_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d        = a;
                    b_d        = b;
                    sgn_d      = signed_mode;
                    idx_d      = IDX_MSB;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    pend_gt_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                cnt_d = cnt_nx;
                if (last_cycle) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    gt_d     = res_vld &  res_gt;
                    lt_d     = res_vld & ~res_gt;
                    eq_d     = ~res_vld;
                    cycles_d = cnt_nx;
                end else begin
                    idx_d      = idx_q - IW'(1);
                    pend_vld_d = res_vld;
                    pend_gt_d  = res_gt;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_gt_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sgn_q      <= sgn_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_gt_q  <= pend_gt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            gt_q       <= gt_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            cycles_q   <= cycles_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign gt     = gt_q;
    assign eq     = eq_q;
    assign lt     = lt_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comp
//
// Three instances share clk/rst_n:
//   k=0 : WIDTH=8, EARLY_EXIT=1
//   k=1 : WIDTH=8, EARLY_EXIT=0
//   k=2 : WIDTH=1, EARLY_EXIT=1
// Expected results come from an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st  [3];
    logic       ism [3];
    logic [7:0] ia  [3];
    logic [7:0] ib  [3];
    logic       ob  [3];
    logic       od  [3];
    logic       ogt [3];
    logic       oeq [3];
    logic       olt [3];
    logic [3:0] ocyc0, ocyc1;
    logic [0:0] ocyc2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_mag_comp #(.WIDTH(8), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(ism[0]),
        .a(ia[0]), .b(ib[0]), .busy(ob[0]), .done(od[0]),
        .gt(ogt[0]), .eq(oeq[0]), .lt(olt[0]), .cycles(ocyc0));

    serial_mag_comp #(.WIDTH(8), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(ism[1]),
        .a(ia[1]), .b(ib[1]), .busy(ob[1]), .done(od[1]),
        .gt(ogt[1]), .eq(oeq[1]), .lt(olt[1]), .cycles(ocyc1));

    serial_mag_comp #(.WIDTH(1), .EARLY_EXIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(ism[2]),
        .a(ia[2][0:0]), .b(ib[2][0:0]), .busy(ob[2]), .done(od[2]),
        .gt(ogt[2]), .eq(oeq[2]), .lt(olt[2]), .cycles(ocyc2));

    function automatic int cyc_of(input int k);
        case (k)
            0:       return int'(ocyc0);
            1:       return int'(ocyc1);
            default: return int'(ocyc2);
        endcase
    endfunction

    function automatic int width_of(input int k);
        return (k == 2) ? 1 : 8;
    endfunction

    function automatic int ee_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: compare as plain integers, count cycles from the position
    // of the highest differing bit.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic sm, input int w, input int ee,
                                  output logic g, output logic e, output logic l,
                                  output int c);
        int am, bm, va, vb, x, p;
        am = int'(a) & ((1 << w) - 1);
        bm = int'(b) & ((1 << w) - 1);
        va = am;
        vb = bm;
        if (sm) begin
            if (am >= (1 << (w - 1))) va = am - (1 << w);
            if (bm >= (1 << (w - 1))) vb = bm - (1 << w);
        end
        g = (va > vb);
        e = (va == vb);
        l = (va < vb);
        x = am ^ bm;
        p = -1;
        for (int i = 0; i < w; i++)
            if (x[i]) p = i;
        c = (ee != 0 && p >= 0) ? (w - p) : w;
    endfunction

    // Waits (bounded) for done on instance k; returns the negedge index
    // counted from the first negedge after acceptance.
    task automatic wait_done(input int k, output int n);
        n = 1;
        while (!od[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge: issues one operation and checks everything.
    task automatic run_op(input string nm, input int k, input logic [7:0] a,
                          input logic [7:0] b, input logic sm,
                          input logic eg, input logic ee_, input logic el,
                          input int ec);
        int n;
        ia[k] = a; ib[k] = b; ism[k] = sm; st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        ia[k] = 8'($urandom);
        ib[k] = 8'($urandom);
        ism[k] = ~sm;
        chk({nm, "_busy"}, int'(ob[k]), 1);
        wait_done(k, n);
        chk({nm, "_lat"}, n, ec + 1);
        chk({nm, "_gt"}, int'(ogt[k]), int'(eg));
        chk({nm, "_eq"}, int'(oeq[k]), int'(ee_));
        chk({nm, "_lt"}, int'(olt[k]), int'(el));
        chk({nm, "_cyc"}, cyc_of(k), ec);
        @(negedge clk);
        chk({nm, "_done_1cyc"}, int'(od[k]), 0);
        chk({nm, "_idle"}, int'(ob[k]), 0);
    endtask

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic       g;
        logic       e;
        logic       l;
        int         c;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, ndone, first;
        logic mg, me, ml;
        int   mc;

        tbl[0]  = '{0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8};
        tbl[1]  = '{0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[2]  = '{0, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[3]  = '{0, 8'h12, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 8};
        tbl[4]  = '{0, 8'hFF, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0, 8};
        tbl[5]  = '{0, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[6]  = '{1, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        tbl[7]  = '{1, 8'h00, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 8};
        tbl[8]  = '{2, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[9]  = '{2, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[10] = '{2, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[11] = '{2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; ism[k] = 1'b0; ia[k] = '0; ib[k] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", int'(ob[0]), 0);
        chk("rst_done", int'(od[0]), 0);
        chk("rst_flags", int'({ogt[0], oeq[0], olt[0]}), 0);
        chk("rst_cycles", cyc_of(0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // start=0 leaves outputs unchanged
        chk("idle_no_done", int'(od[0]), 0);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].k, tbl[i].a, tbl[i].b,
                   tbl[i].sm, tbl[i].g, tbl[i].e, tbl[i].l, tbl[i].c);

        // Start while busy is ignored.
        ia[0] = 8'h40; ib[0] = 8'h00; ism[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        ia[0] = 8'h00; ib[0] = 8'hFF;
        @(negedge clk);
        st[0] = 1'b0;
        ndone = 0; first = 0;
        for (int i = 2; i <= 14; i++) begin
            if (od[0]) begin
                ndone++;
                if (first == 0) first = i;
            end
            @(negedge clk);
        end
        chk("busy_ign_lat", first, 3);
        chk("busy_ign_ndone", ndone, 1);
        chk("busy_ign_gt", int'(ogt[0]), 1);
        chk("busy_ign_cyc", cyc_of(0), 2);

        // Reset asserted during the 4th SHIFT cycle.
        ia[0] = 8'h01; ib[0] = 8'h00; ism[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(ob[0]), 0);
        chk("midrst_flags", int'({ogt[0], oeq[0], olt[0]}), 0);
        chk("midrst_cycles", cyc_of(0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (od[0] || ob[0]) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_flags_hold", int'({ogt[0], oeq[0], olt[0]}), 0);
        run_op("post_rst", 0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 8);

        // Back-to-back on the full-scan instance.
        ia[1] = 8'h80; ib[1] = 8'h00; ism[1] = 1'b0; st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        wait_done(1, n);
        chk("b2b_first_lat", n, 9);
        chk("b2b_first_gt", int'(ogt[1]), 1);
        ia[1] = 8'h00; ib[1] = 8'h80; st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        chk("b2b_accept", int'(ob[1]), 1);
        chk("b2b_flags_held", int'(ogt[1]), 1);
        wait_done(1, n);
        chk("b2b_second_lat", n, 9);
        chk("b2b_second_lt", int'(olt[1]), 1);
        chk("b2b_second_cyc", cyc_of(1), 8);
        @(negedge clk);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            int         k;
            logic [7:0] ra, rb;
            logic       rs;
            k  = int'($urandom_range(0, 2));
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, width_of(k), ee_of(k), mg, me, ml, mc);
            run_op($sformatf("rnd%0d_k%0d", i, k), k, ra, rb, rs, mg, me, ml, mc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
